// File: rtl/mux2_arbiter_pkg.sv
// mux2_arbiter_pkg: shared state encodings and mux select constants for the arbiter
package mux2_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/mux2_arbiter_mux2bit.sv
// MUX2bit: 2-bit two-input multiplexer, control 0 selects a, 1 selects b
module MUX2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       control,
  output logic [1:0] out
);
  assign out = control ? b : a;
endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin burst arbiter sharing MUX2bit between two requesters
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CW        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic [1:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [1:0] data_b,
  output logic       ack_b,
  output logic [1:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sel,
  output logic       busy
);
  state_t        state;
  logic          last;
  logic [CW-1:0] cnt;
  logic          req_g, beat, done, pick_b;
  always_comb begin
    req_g     = state == GRANT_A ? req_a : state == GRANT_B ? req_b : 1'b0;
    out_valid = req_g;
    beat      = req_g & out_ready;
    ack_a     = beat & (state == GRANT_A);
    ack_b     = beat & (state == GRANT_B);
    done      = !req_g || (beat && cnt == CW'(MAX_BURST - 1));
    // on a tie the requester not served last wins
    pick_b    = req_b & (~req_a | ~last);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= SEL_A;
      last  <= SEL_B;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (state == IDLE) begin
      if (req_a | req_b) begin
        state <= pick_b ? GRANT_B : GRANT_A;
        sel   <= pick_b ? SEL_B : SEL_A;
        cnt   <= '0;
        busy  <= 1'b1;
      end
    end else if (done) begin
      state <= IDLE;
      last  <= state == GRANT_B ? SEL_B : SEL_A;
      busy  <= 1'b0;
    end else if (beat) begin
      cnt <= cnt + 1'b1;
    end
  end
  MUX2bit u_mux (
    .a      (data_a),
    .b      (data_b),
    .control(sel),
    .out    (out_data)
  );
endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: vector table, directed corner sequences and randomized model comparison
module tb_mux2_arbiter;
  localparam int MAX_BURST = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0, out_ready = 1'b0;
  logic [1:0] data_a = 2'd0, data_b = 2'd0;
  logic ack_a, ack_b, out_valid, sel, busy;
  logic [1:0] out_data;
  int pass = 0, total = 0;
  int owner, beats, last_srv;
  logic msel;

  always #5 clk = ~clk;

  mux2_arbiter #(.MAX_BURST(MAX_BURST), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel(sel), .busy(busy)
  );

  typedef struct {
    logic ra; logic [1:0] da; logic rb; logic [1:0] db; logic rdy;
    logic vld; logic aa; logic ab; logic [1:0] od; logic sl; logic bsy;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    else pass++;
  endtask

  // owner: 0 none, 1 A, 2 B; each grant may carry up to MAX_BURST beats
  task automatic model_reset();
    owner = 0; beats = 0; last_srv = 2; msel = 1'b0;
  endtask

  task automatic model_tick();
    if (owner == 0) begin
      if (req_a || req_b) begin
        owner = (req_a && req_b) ? (last_srv == 1 ? 2 : 1) : (req_a ? 1 : 2);
        msel = (owner == 2);
        beats = 0;
      end
    end else if (!(owner == 1 ? req_a : req_b)) begin
      last_srv = owner; owner = 0;
    end else if (out_ready) begin
      beats++;
      if (beats == MAX_BURST) begin last_srv = owner; owner = 0; end
    end
  endtask

  task automatic check_model(input string tag);
    logic r;
    r = owner == 1 ? req_a : owner == 2 ? req_b : 1'b0;
    check({tag, ".valid"}, {1'b0, out_valid}, {1'b0, r});
    check({tag, ".ack_a"}, {1'b0, ack_a}, {1'b0, owner == 1 && r && out_ready});
    check({tag, ".ack_b"}, {1'b0, ack_b}, {1'b0, owner == 2 && r && out_ready});
    check({tag, ".data"}, out_data, msel ? data_b : data_a);
    check({tag, ".sel"}, {1'b0, sel}, {1'b0, msel});
    check({tag, ".busy"}, {1'b0, busy}, {1'b0, owner != 0});
  endtask

  task automatic apply(input logic ra, input logic [1:0] da, input logic rb,
                       input logic [1:0] db, input logic rdy);
    req_a = ra; data_a = da; req_b = rb; data_b = db; out_ready = rdy;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 12; i++)
      tbl[i] = '{1'b1, 2'b10, i >= 7, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1};
    tbl[0].vld = 0; tbl[0].aa = 0; tbl[0].bsy = 0;
    tbl[5].vld = 0; tbl[5].aa = 0; tbl[5].bsy = 0;
    tbl[10].vld = 0; tbl[10].aa = 0; tbl[10].bsy = 0;
    tbl[11].aa = 0; tbl[11].ab = 1; tbl[11].od = 2'b11; tbl[11].sl = 1;
    model_reset();
    // reset held with both requests high
    apply(1, 2'b01, 1, 2'b10, 1);
    @(posedge clk); #1; @(posedge clk); #5;
    check("rst.valid", {1'b0, out_valid}, 2'd0);
    check("rst.ack_a", {1'b0, ack_a}, 2'd0);
    check("rst.ack_b", {1'b0, ack_b}, 2'd0);
    check("rst.sel", {1'b0, sel}, 2'd0);
    check("rst.busy", {1'b0, busy}, 2'd0);
    check("rst.data", out_data, 2'b01);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    #4; check_model("rel0"); tick();
    #4; check_model("rel1");
    check("rel1.grant_a", {busy, sel}, 2'b10);
    tick();
    // table: single requester A, then a tie resolved towards B
    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].ra, tbl[i].da, tbl[i].rb, tbl[i].db, tbl[i].rdy);
      check($sformatf("tbl%0d.valid", i), {1'b0, out_valid}, {1'b0, tbl[i].vld});
      check($sformatf("tbl%0d.ack_a", i), {1'b0, ack_a}, {1'b0, tbl[i].aa});
      check($sformatf("tbl%0d.ack_b", i), {1'b0, ack_b}, {1'b0, tbl[i].ab});
      check($sformatf("tbl%0d.data", i), out_data, tbl[i].od);
      check($sformatf("tbl%0d.sel", i), {1'b0, sel}, {1'b0, tbl[i].sl});
      check($sformatf("tbl%0d.busy", i), {1'b0, busy}, {1'b0, tbl[i].bsy});
      tick();
    end
    // tie round robin: A x4, idle, B x4, idle, A x4
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply(1, 2'b00, 1, 2'b11, 1);
      check_model($sformatf("tie%0d", i));
      if (i == 3) check("tie.sel_a", {1'b0, sel}, 2'd0);
      if (i == 8) check("tie.sel_b", {1'b0, sel}, 2'd1);
      if (i == 13) check("tie.sel_a2", {1'b0, sel}, 2'd0);
      tick();
    end
    // backpressure in GRANT_B
    do_reset();
    apply(0, 2'b00, 1, 2'b01, 1); check_model("bp.idle"); tick();
    apply(0, 2'b00, 1, 2'b01, 1); check_model("bp.b1"); tick();
    for (int i = 0; i < 3; i++) begin
      apply(0, 2'b00, 1, 2'b01, 0);
      check($sformatf("bp.stall%0d.valid", i), {1'b0, out_valid}, 2'd1);
      check($sformatf("bp.stall%0d.ack_b", i), {1'b0, ack_b}, 2'd0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      apply(0, 2'b00, 1, 2'b01, 1);
      check_model($sformatf("bp.resume%0d", i));
      tick();
    end
    check("bp.data", out_data, 2'b01);
    // withdrawal of A after two beats, pending B granted next
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1, 2'b10, 1, 2'b01, 1); check_model($sformatf("wd%0d", i)); tick();
    end
    apply(0, 2'b10, 1, 2'b01, 1); check_model("wd.drop"); tick();
    apply(0, 2'b10, 1, 2'b01, 1); check_model("wd.idle");
    check("wd.idle_busy", {1'b0, busy}, 2'd0); tick();
    apply(0, 2'b10, 1, 2'b01, 1); check_model("wd.grant_b");
    check("wd.grant_b_ack", {1'b0, ack_b}, 2'd1); tick();
    // reset mid-burst after beat 2 of B
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(0, 2'b00, 1, 2'b10, 1); check_model($sformatf("mr%0d", i)); tick();
    end
    req_b = 1'b1; out_ready = 1'b1;
    #2; rst_n = 1'b0; #1;
    check("mr.valid", {1'b0, out_valid}, 2'd0);
    check("mr.ack_b", {1'b0, ack_b}, 2'd0);
    check("mr.busy", {1'b0, busy}, 2'd0);
    check("mr.sel", {1'b0, sel}, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 3) != 0,
            2'($urandom), $urandom_range(0, 2) != 0);
      check_model($sformatf("rnd%0d", i));
      tick();
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
